// File: rtl/irq_scheduler_if.sv
// irq_scheduler_if
//   CPU-side bus between the i8080 and the interrupt scheduler.
//   sync / dbin / status_in : driven by the CPU (status strobe, data-in strobe, data bus)
//   iint                    : interrupt request back to the CPU
//   vector / vector_oe      : RST opcode and its drive enable for the tristate data bus
//   master = CPU side, slave = scheduler side.
interface irq_scheduler_if;
    logic       sync;
    logic       dbin;
    logic [7:0] status_in;
    logic       iint;
    logic [7:0] vector;
    logic       vector_oe;

    modport master (
        output sync, dbin, status_in,
        input  iint, vector, vector_oe
    );

    modport slave (
        input  sync, dbin, status_in,
        output iint, vector, vector_oe
    );
endinterface

// File: rtl/irq_scheduler.sv
// irq_scheduler
//   Turns rising edges of the video mid_screen / vblank levels into pending
//   interrupt requests, raises iint to the i8080 and answers the INTA bus cycle
//   with RST 1 (8'hCF, mid_screen) or RST 2 (8'hD7, vblank); 8'h00 when nothing
//   is pending and enabled.
// Ports
//   clk, rst        : CPU clock, synchronous active-high reset
//   mid_screen      : async video level, source 0
//   vblank          : async video level, source 1
//   irq_mask[1:0]   : per-source enable, 1 = enabled
//   bus             : CPU bus (sync, dbin, status_in in; iint, vector, vector_oe out)
//   pending[1:0]    : pending request flags
//   overrun_count   : saturating count of edges lost to an already pending source
module irq_scheduler #(
    parameter int SYNC_STAGES = 2,
    parameter int INTA_BIT    = 0,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mid_screen,
    input  logic                 vblank,
    input  logic [1:0]           irq_mask,
    irq_scheduler_if.slave       bus,
    output logic [1:0]           pending,
    output logic [CNT_WIDTH-1:0] overrun_count
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t                state_reg, state_next;
    logic [1:0]            pending_reg;
    logic [1:0]            grant_reg, grant_next;   // one-hot granted source, 0 = none
    logic [7:0]            vector_reg, vector_next;
    logic [7:0]            stat_reg;
    logic                  iint_reg;
    logic [CNT_WIDTH-1:0]  count_reg, count_next;
    logic [SYNC_STAGES:0]  warm_reg;
    logic [1:0]            src_in;
    logic [1:0]            edge_det;
    logic [1:0]            req;
    logic [1:0]            clr_mask;
    logic [1:0]            overrun;
    logic [1:0]            inc;
    logic [CNT_WIDTH:0]    sum;
    logic                  vector_oe;

    assign src_in = {vblank, mid_screen};

    // The synchronizers come out of reset holding 0, so a level that is already
    // high at reset release would look like a rise. warm_reg fills with ones
    // after reset and edges are ignored until every flop in the input path holds
    // a real post-reset sample.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic [SYNC_STAGES-1:0] chain_reg;
            logic                   prev_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    chain_reg <= '0;
                    prev_reg  <= 1'b0;
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], src_in[gi]};
                    prev_reg  <= chain_reg[SYNC_STAGES-1];
                end
            end

            assign edge_det[gi] = chain_reg[SYNC_STAGES-1] & ~prev_reg & warm_reg[SYNC_STAGES];
        end
    endgenerate

    assign req = pending_reg & irq_mask;

    // FSM next state and outputs
    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        vector_next = vector_reg;
        clr_mask    = 2'b00;
        vector_oe   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.dbin && stat_reg[INTA_BIT]) begin
                    state_next = ACK;
                    // mid_screen (source 0) has priority over vblank
                    if (req[0]) begin
                        grant_next  = 2'b01;
                        vector_next = 8'hCF;
                    end else if (req[1]) begin
                        grant_next  = 2'b10;
                        vector_next = 8'hD7;
                    end else begin
                        grant_next  = 2'b00;
                        vector_next = 8'h00;
                    end
                end
            end
            ACK: begin
                if (bus.dbin) begin
                    vector_oe = 1'b1;
                end else begin
                    state_next = IDLE;
                    clr_mask   = grant_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A fresh edge on the source being cleared wins and is not an overrun.
    assign overrun    = edge_det & pending_reg & ~clr_mask;
    assign inc        = {1'b0, overrun[0]} + {1'b0, overrun[1]};
    assign sum        = {1'b0, count_reg} + {{(CNT_WIDTH-1){1'b0}}, inc};
    assign count_next = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            grant_reg   <= 2'b00;
            vector_reg  <= 8'h00;
            stat_reg    <= 8'h00;
            pending_reg <= 2'b00;
            iint_reg    <= 1'b0;
            count_reg   <= '0;
            warm_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            vector_reg  <= vector_next;
            if (bus.sync) begin
                stat_reg <= bus.status_in;
            end
            pending_reg <= (pending_reg & ~clr_mask) | edge_det;
            iint_reg    <= |req;
            count_reg   <= count_next;
            warm_reg    <= {warm_reg[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign bus.iint      = iint_reg;
    assign bus.vector    = vector_reg;
    assign bus.vector_oe = vector_oe;
    assign pending       = pending_reg;
    assign overrun_count = count_reg;

endmodule
